// File: rtl/mdr_seq_unit_if.sv
// Handshake and data bundle between a host and the MDR sequential unit.
// The host drives op/data/start/load; the unit answers with requests and results.
interface mdr_seq_unit_if #(
  parameter int WIDTH = 16
) ();
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic             start;
  logic             load;
  logic             load_x;
  logic             load_y;
  logic             ready;
  logic             error;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] remainder;

  modport master (
    output op, data, start, load,
    input  load_x, load_y, ready, error, result, remainder
  );

  modport slave (
    input  op, data, start, load,
    output load_x, load_y, ready, error, result, remainder
  );
endinterface

// File: rtl/mdr_seq_unit.sv
// Sequential multiply / divide / square-root unit with serial operand loading.
// Iterates on operand magnitudes and applies sign and error checks at the end.
module mdr_seq_unit #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  mdr_seq_unit_if.slave bus
);

  localparam int H  = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1) + 1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_CALC,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic [H-1:0]     r_root;
  logic             r_err;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_rem;

  logic             w_sx;
  logic             w_sy;
  logic [WIDTH-1:0] w_mx;
  logic [WIDTH-1:0] w_my;
  logic [CW-1:0]    w_n;
  logic             w_last;

  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_dsh;
  logic             w_dge;
  logic [WIDTH-1:0] w_ddif;
  logic [WIDTH+1:0] w_ssh;
  logic [WIDTH+1:0] w_strial;
  logic             w_sge;
  logic [WIDTH-1:0] w_sdif;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_sprod;
  logic               w_mul_ovf;
  logic               w_div_ovf;
  logic               w_err;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   w_rem;

  assign w_sx = SIGNED_EN && r_x[WIDTH-1];
  assign w_sy = SIGNED_EN && r_y[WIDTH-1];
  assign w_mx = w_sx ? -r_x : r_x;
  assign w_my = w_sy ? -r_y : r_y;

  assign w_n    = (r_op == OP_SQRT) ? CW'(H) : CW'(WIDTH);
  assign w_last = (r_cnt == w_n);

  // shift-add: {r_acc, r_q} is the running product
  assign w_msum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);

  // restoring: r_acc is the partial remainder, r_q the dividend/quotient
  assign w_dsh  = {r_acc, r_q[WIDTH-1]};
  assign w_dge  = (w_dsh >= {1'b0, r_m});
  assign w_ddif = WIDTH'(w_dsh - {1'b0, r_m});

  // digit-by-digit root: two radicand bits enter per step
  assign w_ssh    = {r_acc, r_q[WIDTH-1 -: 2]};
  assign w_strial = (WIDTH+2)'({r_root, 2'b01});
  assign w_sge    = (w_ssh >= w_strial);
  assign w_sdif   = WIDTH'(w_ssh - w_strial);

  assign w_prod  = {r_acc, r_q};
  assign w_sprod = (w_sx ^ w_sy) ? -w_prod : w_prod;

  assign w_mul_ovf = SIGNED_EN
    ? !((&w_sprod[2*WIDTH-1:WIDTH-1]) ||
        !(|w_sprod[2*WIDTH-1:WIDTH-1]))
    : (|w_prod[2*WIDTH-1:WIDTH]);

  assign w_div_ovf = SIGNED_EN && (r_x == MIN_NEG) && (&r_y);

  always_comb begin
    w_err = 1'b0;
    w_res = '0;
    w_rem = '0;
    unique case (r_op)
      OP_MUL: begin
        w_err = w_mul_ovf;
        w_res = w_sprod[WIDTH-1:0];
      end
      OP_DIV: begin
        if (r_y == '0) begin
          w_err = 1'b1;
        end else begin
          w_err = w_div_ovf;
          w_res = (w_sx ^ w_sy) ? -r_q : r_q;
          w_rem = w_sx ? -r_acc : r_acc;
        end
      end
      OP_SQRT: begin
        if (w_sx) begin
          w_err = 1'b1;
        end else begin
          w_res = WIDTH'(r_root);
          w_rem = r_acc;
        end
      end
      OP_RSV: begin
        w_err = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_next = (bus.op == OP_RSV) ? S_DONE : S_LOAD_X;
      end
      S_LOAD_X: begin
        if (bus.load)
          w_next = (r_op == OP_SQRT) ? S_CALC : S_LOAD_Y;
      end
      S_LOAD_Y: begin
        if (bus.load)
          w_next = S_CALC;
      end
      S_CALC: begin
        if (w_last)
          w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= OP_MUL;
      r_x    <= '0;
      r_y    <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_m    <= '0;
      r_root <= '0;
      r_err  <= 1'b0;
      r_res  <= '0;
      r_rem  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (bus.start) begin
            r_op  <= bus.op;
            r_err <= 1'b0;
          end
        end
        S_LOAD_X: begin
          if (bus.load)
            r_x <= bus.data;
        end
        S_LOAD_Y: begin
          if (bus.load)
            r_y <= bus.data;
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          // first CALC cycle conditions operands into magnitude form
          if (r_cnt == '0) begin
            r_acc  <= '0;
            r_root <= '0;
            unique case (r_op)
              OP_MUL: begin
                r_q <= w_my;
                r_m <= w_mx;
              end
              OP_DIV: begin
                r_q <= w_mx;
                r_m <= w_my;
              end
              default: begin
                r_q <= r_x;
                r_m <= '0;
              end
            endcase
          end else begin
            unique case (r_op)
              OP_MUL: begin
                r_acc <= w_msum[WIDTH:1];
                r_q   <= {w_msum[0], r_q[WIDTH-1:1]};
              end
              OP_DIV: begin
                r_acc <= w_dge ? w_ddif : w_dsh[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_dge};
              end
              default: begin
                r_acc  <= w_sge ? w_sdif : w_ssh[WIDTH-1:0];
                r_root <= {r_root[H-2:0], w_sge};
                r_q    <= {r_q[WIDTH-3:0], 2'b00};
              end
            endcase
          end
        end
        S_DONE: begin
          r_cnt <= '0;
          r_err <= w_err;
          r_res <= w_res;
          r_rem <= w_rem;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.ready     = (r_state == S_IDLE);
  assign bus.load_x    = (r_state == S_LOAD_X);
  assign bus.load_y    = (r_state == S_LOAD_Y);
  assign bus.error     = r_err;
  assign bus.result    = r_res;
  assign bus.remainder = r_rem;

endmodule

// File: tb/tb_mdr_seq_unit.sv
// Bench for mdr_seq_unit: a 16-bit signed and an 8-bit unsigned instance
// driven with directed and random operations against an arithmetic model.
module tb_mdr_seq_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mdr_seq_unit_if #(.WIDTH(16)) if16 ();
  mdr_seq_unit_if #(.WIDTH(8))  if8 ();

  mdr_seq_unit #(.WIDTH(16), .SIGNED_EN(1'b1)) u16 (
    .clk (clk),
    .rst (rst),
    .bus (if16)
  );

  mdr_seq_unit #(.WIDTH(8), .SIGNED_EN(1'b0)) u8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drv(input bit s8, input logic st, input logic ld,
                     input logic [1:0] op, input logic [63:0] d);
    if (s8) begin
      if8.start = st;
      if8.load  = ld;
      if8.op    = op;
      if8.data  = d[7:0];
    end else begin
      if16.start = st;
      if16.load  = ld;
      if16.op    = op;
      if16.data  = d[15:0];
    end
  endtask

  function automatic logic [63:0] rd(input bit s8, input int k);
    logic [63:0] v;
    v = '0;
    if (s8) begin
      case (k)
        0: v = 64'(if8.ready);
        1: v = 64'(if8.load_x);
        2: v = 64'(if8.load_y);
        3: v = 64'(if8.error);
        4: v = 64'(if8.result);
        5: v = 64'(if8.remainder);
        default: v = '0;
      endcase
    end else begin
      case (k)
        0: v = 64'(if16.ready);
        1: v = 64'(if16.load_x);
        2: v = 64'(if16.load_y);
        3: v = 64'(if16.error);
        4: v = 64'(if16.result);
        5: v = 64'(if16.remainder);
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  // Arithmetic reference using plain integer math on w-bit operands
  task automatic model(input int w, input bit sg, input logic [1:0] op,
                       input logic [63:0] xr, input logic [63:0] yr,
                       output bit e, output logic [63:0] res,
                       output logic [63:0] rem);
    longint m, x, y, p, q, r, s, lo, hi;
    m  = (longint'(1) << w) - 1;
    x  = longint'(xr) & m;
    y  = longint'(yr) & m;
    if (sg) begin
      if (x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
      if (y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    end
    lo  = sg ? -(longint'(1) << (w - 1)) : 0;
    hi  = sg ? (longint'(1) << (w - 1)) - 1 : m;
    e   = 1'b0;
    res = '0;
    rem = '0;
    case (op)
      2'b00: begin
        p   = x * y;
        e   = (p < lo) || (p > hi);
        res = 64'(p & m);
      end
      2'b01: begin
        if (y == 0) begin
          e = 1'b1;
        end else begin
          q   = x / y;
          r   = x % y;
          e   = (q > hi);
          res = 64'(q & m);
          rem = 64'(r & m);
        end
      end
      2'b10: begin
        if (x < 0) begin
          e = 1'b1;
        end else begin
          s = 0;
          while ((s + 1) * (s + 1) <= x) s++;
          res = 64'(s);
          rem = 64'(x - s * s);
        end
      end
      default: e = 1'b1;
    endcase
  endtask

  // One full operation; optional start+load collision on the start cycle
  task automatic txn(input bit s8, input logic [1:0] op,
                     input logic [63:0] x, input logic [63:0] y,
                     input bit both, input string tag);
    int w, n, edges;
    bit e;
    logic [63:0] er, em;
    w = s8 ? 8 : 16;
    n = (op == 2'b10) ? w / 2 : w;
    model(w, !s8, op, x, y, e, er, em);
    @(negedge clk);
    drv(s8, 1'b1, both, op, both ? ~x : 64'd0);
    @(negedge clk);
    drv(s8, 1'b0, 1'b0, 2'($urandom), 64'($urandom));
    if (op == 2'b11) begin
      chk({tag, ".ldx"}, rd(s8, 1), 64'd0);
      chk({tag, ".rdy0"}, rd(s8, 0), 64'd0);
      @(negedge clk);
      chk({tag, ".rdy"}, rd(s8, 0), 64'd1);
    end else begin
      chk({tag, ".ldx"}, rd(s8, 1), 64'd1);
      drv(s8, 1'b0, 1'b1, 2'($urandom), x);
      @(negedge clk);
      drv(s8, 1'b0, 1'b0, 2'($urandom), 64'($urandom));
      if (op != 2'b10) begin
        chk({tag, ".ldy"}, rd(s8, 2), 64'd1);
        drv(s8, 1'b0, 1'b1, 2'($urandom), y);
        @(negedge clk);
        drv(s8, 1'b0, 1'b0, 2'($urandom), 64'($urandom));
      end else begin
        chk({tag, ".noldy"}, rd(s8, 2), 64'd0);
      end
      edges = 0;
      while (rd(s8, 0) !== 64'd1 && edges < 64) begin
        drv(s8, edges == 2, edges == 2, 2'($urandom), 64'($urandom));
        @(negedge clk);
        edges++;
      end
      drv(s8, 1'b0, 1'b0, 2'($urandom), 64'($urandom));
      chk({tag, ".lat"}, 64'(edges), 64'(n + 2));
    end
    chk({tag, ".err"}, rd(s8, 3), 64'(e));
    chk({tag, ".res"}, rd(s8, 4), er);
    chk({tag, ".rem"}, rd(s8, 5), em);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] x, y;
    logic [1:0]  op;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 2'b00, 64'd0);
    drv(1'b1, 1'b0, 1'b0, 2'b00, 64'd0);
    repeat (3) @(negedge clk);
    chk("rst.rdy", rd(1'b0, 0), 64'd1);
    chk("rst.ldx", rd(1'b0, 1), 64'd0);
    chk("rst.ldy", rd(1'b0, 2), 64'd0);
    chk("rst.err", rd(1'b0, 3), 64'd0);
    chk("rst.res", rd(1'b0, 4), 64'd0);
    chk("rst.rem", rd(1'b0, 5), 64'd0);
    chk("rst8.rdy", rd(1'b1, 0), 64'd1);
    rst = 1'b0;

    txn(1'b0, 2'b00, 64'd7, -64'sd6, 1'b0, "mul_7x-6");
    txn(1'b0, 2'b00, 64'd300, 64'd300, 1'b0, "mul_ovf");
    txn(1'b0, 2'b01, -64'sd17, 64'd5, 1'b0, "div_-17/5");
    txn(1'b0, 2'b01, 64'd100, 64'd0, 1'b0, "div_by0");
    txn(1'b0, 2'b10, 64'd200, 64'd0, 1'b1, "sqrt_200");
    txn(1'b0, 2'b10, -64'sd4, 64'd0, 1'b0, "sqrt_neg");
    txn(1'b0, 2'b11, 64'd0, 64'd0, 1'b0, "rsv");
    txn(1'b0, 2'b01, 64'h8000, -64'sd1, 1'b0, "div_ovf");

    @(negedge clk);
    drv(1'b0, 1'b1, 1'b0, 2'b00, 64'd0);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b1, 2'b00, 64'd5);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b1, 2'b00, 64'd9);
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0, 2'b00, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.rdy", rd(1'b0, 0), 64'd1);
    chk("midrst.ldx", rd(1'b0, 1), 64'd0);
    chk("midrst.err", rd(1'b0, 3), 64'd0);
    chk("midrst.res", rd(1'b0, 4), 64'd0);
    chk("midrst.rem", rd(1'b0, 5), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(1'b0, 2'b00, 64'd3, 64'd4, 1'b0, "mul_3x4");
    txn(1'b1, 2'b00, 64'd16, 64'd16, 1'b0, "u8_mul_ovf");
    txn(1'b1, 2'b10, 64'd255, 64'd0, 1'b0, "u8_sqrt_255");
    txn(1'b1, 2'b01, 64'd250, 64'd7, 1'b1, "u8_div");

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom_range(0, 1) ? 64'($urandom)
                                : 64'($signed(8'($urandom)));
      y  = ($urandom_range(0, 7) == 0) ? 64'd0
         : $urandom_range(0, 1) ? 64'($urandom)
                                : 64'($signed(8'($urandom)));
      txn(1'b0, op, x, y, 1'($urandom), "rnd16");
    end
    for (int i = 0; i < 25; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = 64'($urandom_range(0, 255));
      y  = ($urandom_range(0, 7) == 0) ? 64'd0
                                       : 64'($urandom_range(0, 31));
      txn(1'b1, op, x, y, 1'($urandom), "rnd8");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
